// File: rtl/exu_pkg.sv
// Shared definitions for the execution-unit arbiter: op bit positions,
// exception codes, sequencer states and the op-legality check.
package exu_pkg;

  localparam int SIGW = 20;

  localparam int OP_MUL    = 0;
  localparam int OP_MULH   = 1;
  localparam int OP_MULHSU = 2;
  localparam int OP_MULHU  = 3;
  localparam int OP_DIV    = 4;
  localparam int OP_DIVU   = 5;
  localparam int OP_REM    = 6;
  localparam int OP_REMU   = 7;
  localparam int OP_FADD   = 8;
  localparam int OP_FSUB   = 9;
  localparam int OP_FMUL   = 10;
  localparam int OP_FDIV   = 11;
  localparam int OP_FEQ    = 12;
  localparam int OP_FLT    = 13;
  localparam int OP_FLE    = 14;
  localparam int OP_FSGNJ  = 15;
  localparam int OP_FSGNJN = 16;

  localparam logic [2:0] EXC_NONE    = 3'b000;
  localparam logic [2:0] EXC_TIMEOUT = 3'b110;
  localparam logic [2:0] EXC_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // The EXU only answers ops with exactly one of the defined bits set.
  function automatic logic is_legal_sig(input logic [SIGW-1:0] sig);
    return (sig[SIGW-1:17] == '0) && $onehot(sig[16:0]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requester at or above ptr,
// wrapping modulo NREQ, wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            any
);

  // Walk from the farthest candidate back to ptr so the closest one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        grant                               = '0;
        grant[(int'(ptr) + k) % NREQ]       = 1'b1;
        grant_idx                           = PW'((int'(ptr) + k) % NREQ);
        any                                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exu_arbiter.sv
// Shares one multi-cycle execution unit between NREQ requesters, with one op
// in flight, illegal-op filtering and a watchdog against a silent EXU.
module exu_arbiter #(
  parameter int NREQ    = 2,
  parameter int SIGW    = 20,
  parameter int TIMEOUT = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*SIGW-1:0] req_sig,
  input  logic [NREQ*32-1:0]   req_src1,
  input  logic [NREQ*32-1:0]   req_src2,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_result,
  output logic [2:0]           resp_exception,
  output logic [SIGW-1:0]      ex_sig,
  output logic [31:0]          ex_src1,
  output logic [31:0]          ex_src2,
  output logic                 ex_out_valid,
  input  logic [31:0]          ex_result,
  input  logic [2:0]           ex_exception,
  input  logic                 ex_in_valid,
  output logic                 timeout_err,
  output logic                 busy
);
  import exu_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);
  // The watchdog starts at 0 in the first WAIT cycle, so this value at an
  // edge means TIMEOUT cycles have passed since the issue cycle began.
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 2);

  state_t          state_reg, state_next;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   owner_reg;
  logic [WW-1:0]   wdog_reg;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic [SIGW-1:0] sel_sig;
  logic [31:0]     sel_src1;
  logic [31:0]     sel_src2;
  logic            sel_legal;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign sel_sig   = req_sig[grant_idx*SIGW +: SIGW];
  assign sel_src1  = req_src1[grant_idx*32 +: 32];
  assign sel_src2  = req_src2[grant_idx*32 +: 32];
  assign sel_legal = is_legal_sig(sel_sig);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_any) begin
          state_next = sel_legal ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (ex_in_valid || (wdog_reg == WDOG_LAST)) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    resp_valid   = '0;
    ex_out_valid = 1'b0;
    busy         = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE:  if (!rst) req_ready = grant;
      ST_ISSUE: ex_out_valid = 1'b1;
      ST_RESP:  resp_valid[owner_reg] = 1'b1;
      default: ;
    endcase
  end

  // Operand, owner, watchdog and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= '0;
      owner_reg      <= '0;
      wdog_reg       <= '0;
      ex_sig         <= '0;
      ex_src1        <= '0;
      ex_src2        <= '0;
      resp_result    <= '0;
      resp_exception <= EXC_NONE;
      timeout_err    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            ex_sig     <= sel_sig;
            ex_src1    <= sel_src1;
            ex_src2    <= sel_src2;
            owner_reg  <= grant_idx;
            rr_ptr_reg <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            if (!sel_legal) begin
              resp_result    <= '0;
              resp_exception <= EXC_ILLEGAL;
            end
          end
        end
        ST_ISSUE: wdog_reg <= '0;
        ST_WAIT: begin
          // A real completion on the expiry edge takes priority.
          if (ex_in_valid) begin
            resp_result    <= ex_result;
            resp_exception <= ex_exception;
          end else if (wdog_reg == WDOG_LAST) begin
            resp_result    <= '0;
            resp_exception <= EXC_TIMEOUT;
            timeout_err    <= 1'b1;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exu_arbiter.sv
// Directed bench for exu_arbiter: a table of single-requester ops plus
// hand-written contention, spurious-completion and reset-abort sequences.
module tb_exu_arbiter;
  localparam int NREQ = 2;
  localparam int SIGW = 20;
  localparam int TMO  = 25;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*SIGW-1:0] req_sig;
  logic [NREQ*32-1:0]   req_src1;
  logic [NREQ*32-1:0]   req_src2;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_result;
  logic [2:0]           resp_exception;
  logic [SIGW-1:0]      ex_sig;
  logic [31:0]          ex_src1;
  logic [31:0]          ex_src2;
  logic                 ex_out_valid;
  logic [31:0]          ex_result;
  logic [2:0]           ex_exception;
  logic                 ex_in_valid;
  logic                 timeout_err;
  logic                 busy;

  exu_arbiter #(
    .NREQ    (NREQ),
    .SIGW    (SIGW),
    .TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_sig        (req_sig),
    .req_src1       (req_src1),
    .req_src2       (req_src2),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_result    (resp_result),
    .resp_exception (resp_exception),
    .ex_sig         (ex_sig),
    .ex_src1        (ex_src1),
    .ex_src2        (ex_src2),
    .ex_out_valid   (ex_out_valid),
    .ex_result      (ex_result),
    .ex_exception   (ex_exception),
    .ex_in_valid    (ex_in_valid),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [19:0] sig;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic [2:0]  exc;
    logic [31:0] exp_res;
    logic [2:0]  exp_exc;
    int          exp_iss;
    int          exp_lat;
    logic        exp_terr;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // EXU model state: answers lat cycles after the issue cycle (lat<=0: never).
  int          exu_lat = 0;
  logic [31:0] exu_res = '0;
  logic [2:0]  exu_exc = '0;
  int          exu_cnt = 0;
  bit          exu_pend = 1'b0;
  bit          spur = 1'b0;

  int issue_cnt = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  int last_inv_cyc = -100;
  int min_gap = 1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, observe the new cycle's outputs, then drive the EXU side.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ex_out_valid) begin
      issue_cnt++;
      if (cyc - last_inv_cyc < min_gap) min_gap = cyc - last_inv_cyc;
    end
    if (resp_valid != '0) begin
      resp_cnt++;
      resp_cyc = cyc;
    end
    ex_in_valid  = spur;
    ex_result    = spur ? 32'h5555_AAAA : 32'h0;
    ex_exception = 3'b000;
    if (exu_pend) begin
      exu_cnt--;
      if (exu_cnt == 1) begin
        ex_in_valid  = 1'b1;
        ex_result    = exu_res;
        ex_exception = exu_exc;
        exu_pend     = 1'b0;
        last_inv_cyc = cyc;
      end
    end
    if (ex_out_valid && exu_lat > 0) begin
      exu_pend = 1'b1;
      exu_cnt  = exu_lat;
    end
  endtask

  // One op from a single requester, started in IDLE and ending back in IDLE.
  task automatic do_op(input vec_t v);
    int iss0, rc0, acc_cyc, n, ready_bad;
    exu_lat = v.lat;
    exu_res = v.res;
    exu_exc = v.exc;
    req_sig[v.r*SIGW +: SIGW] = v.sig;
    req_src1[v.r*32 +: 32]    = v.a;
    req_src2[v.r*32 +: 32]    = v.b;
    req_valid                 = '0;
    req_valid[v.r]            = 1'b1;
    #1;
    chk("grant", req_ready, 64'(1 << v.r));
    iss0 = issue_cnt;
    rc0  = resp_cnt;
    tick();
    acc_cyc = cyc;
    if (v.exp_iss != 0) begin
      chk("ex_sig", ex_sig, v.sig);
      chk("ex_src1", ex_src1, v.a);
      chk("ex_src2", ex_src2, v.b);
    end
    ready_bad = 0;
    n = 0;
    while (resp_cnt == rc0 && n < TMO + 10) begin
      if (req_ready != '0) ready_bad++;
      tick();
      n++;
    end
    if (req_ready != '0) ready_bad++;
    chk("resp_count", resp_cnt - rc0, 1);
    chk("resp_valid", resp_valid, 64'(1 << v.r));
    chk("resp_result", resp_result, v.exp_res);
    chk("resp_exc", resp_exception, v.exp_exc);
    chk("issue_count", issue_cnt - iss0, v.exp_iss);
    chk("latency", resp_cyc - acc_cyc, v.exp_lat);
    chk("ready_low", ready_bad, 0);
    chk("timeout_err", timeout_err, v.exp_terr);
    $display("op r=%0d sig=%05h result=%08h exc=%0d lat=%0d", v.r, v.sig, resp_result,
             resp_exception, resp_cyc - acc_cyc);
    req_valid = '0;
    tick();
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v1;
    int   rc0, iss0, n;

    vecs[0] = '{0, 20'h00001, 32'd7, 32'd6, 5, 32'd42, 3'b000, 32'd42, 3'b000, 1, 5, 1'b0};
    vecs[1] = '{1, 20'h00003, 32'd1, 32'd1, 0, 32'd0, 3'b000, 32'd0, 3'b111, 0, 0, 1'b0};
    vecs[2] = '{1, 20'h20000, 32'd2, 32'd2, 0, 32'd0, 3'b000, 32'd0, 3'b111, 0, 0, 1'b0};
    vecs[3] = '{1, 20'h00800, 32'd1, 32'd2, 3, 32'h3F80_0000, 3'b001, 32'h3F80_0000, 3'b001, 1, 3, 1'b0};
    vecs[4] = '{0, 20'h00100, 32'hA, 32'hB, 2, 32'h1234_5678, 3'b000, 32'h1234_5678, 3'b000, 1, 2, 1'b0};
    vecs[5] = '{1, 20'h00400, 32'h3, 32'h4, TMO, 32'hDEAD_BEEF, 3'b000, 32'hDEAD_BEEF, 3'b000, 1, TMO, 1'b0};
    vecs[6] = '{0, 20'h00010, 32'd9, 32'd0, 0, 32'd0, 3'b000, 32'd0, 3'b110, 1, TMO, 1'b1};
    vecs[7] = '{1, 20'h00000, 32'd5, 32'd5, 0, 32'd0, 3'b000, 32'd0, 3'b111, 0, 0, 1'b1};

    rst          = 1'b1;
    req_valid    = '1;
    req_sig      = {20'h00001, 20'h00001};
    req_src1     = '0;
    req_src2     = '0;
    ex_in_valid  = 1'b0;
    ex_result    = '0;
    ex_exception = '0;
    repeat (3) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", ex_out_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ex_sig", ex_sig, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst       = 1'b0;
    req_valid = '0;
    tick();

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // A completion pulse while idle must not produce a response.
    rc0  = resp_cnt;
    iss0 = issue_cnt;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) tick();
    chk("spur_no_resp", resp_cnt - rc0, 0);
    chk("spur_no_issue", issue_cnt - iss0, 0);
    chk("spur_idle", busy, 0);
    $display("spurious ex_in_valid in IDLE: resp pulses=%0d", resp_cnt - rc0);

    // Abort an fdiv in WAIT with an asynchronous reset between edges.
    exu_lat  = 40;
    req_sig[0 +: SIGW] = 20'h00800;
    req_src1[0 +: 32]  = 32'd77;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    repeat (2) tick();
    chk("pre_rst_busy", busy, 1);
    rc0 = resp_cnt;
    #3;
    rst       = 1'b1;
    exu_pend  = 1'b0;
    req_valid = 2'b10;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ex_src1", ex_src1, 0);
    chk("arst_ex_sig", ex_sig, 0);
    chk("arst_timeout_err", timeout_err, 0);
    chk("arst_ready", req_ready, 0);
    repeat (2) tick();
    rst       = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    chk("arst_no_resp", resp_cnt - rc0, 0);
    $display("reset mid-WAIT: resp pulses=%0d", resp_cnt - rc0);

    // Both requesters held for four ops: grants must alternate from 0.
    exu_lat  = 4;
    exu_exc  = 3'b000;
    req_sig  = {20'h00100, 20'h00100};
    req_src1 = {32'd201, 32'd200};
    req_src2 = {32'd301, 32'd300};
    req_valid = 2'b11;
    min_gap  = 1000;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("cont_grant", req_ready, 64'(1 << (k % 2)));
      exu_res = 32'd100 + 32'(k);
      rc0 = resp_cnt;
      tick();
      chk("cont_src1", ex_src1, 32'd200 + 32'(k % 2));
      n = 0;
      while (resp_cnt == rc0 && n < TMO + 10) begin
        tick();
        n++;
      end
      chk("cont_owner", resp_valid, 64'(1 << (k % 2)));
      chk("cont_result", resp_result, 32'd100 + 32'(k));
      $display("contention op %0d: resp_valid=%b result=%0d", k, resp_valid, resp_result);
      tick();
    end
    chk("cont_gap_ok", min_gap >= 2, 1);
    req_valid = '0;
    tick();

    v1 = '{1, 20'h00800, 32'd8, 32'd2, 3, 32'h4080_0000, 3'b000, 32'h4080_0000, 3'b000, 1, 3, 1'b0};
    do_op(v1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/exu_arbiter.md
Name: exu_arbiter

Overview:
- Shares the single multi-cycle execution unit (int mul/div, FP add/sub/mul/div/compare/sign-inject) between NREQ requesters, e.g. the integer pipe and the FP pipe.
- Per-requester valid/ready input side; one-op-in-flight sequencer driving the EXU pulse handshake (ex_out_valid out, ex_in_valid back).
- Returns each result tagged to its requester.
- Guards the EXU against malformed op signals and against hangs (watchdog).

Parameters:
- NREQ, 2, number of requesters; legal 2..4.
- SIGW, 20, width of the one-hot op signal.
- TIMEOUT, 100, cycles to wait for ex_in_valid after issue before aborting; must be > 18.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  requester i has an op.
- req_sig  in  NREQ*SIGW  op one-hot per requester; requester i at [i*SIGW +: SIGW].
- req_src1  in  NREQ*32  operand 1 per requester.
- req_src2  in  NREQ*32  operand 2 per requester.
- req_ready  out  NREQ  grant; at most one bit high.
- resp_valid  out  NREQ  one-cycle result pulse to the owning requester.
- resp_result  out  32  result, shared by all requesters.
- resp_exception  out  3  exception code, shared by all requesters.
- ex_sig  out  SIGW  op to EXU.
- ex_src1  out  32  operand 1 to EXU.
- ex_src2  out  32  operand 2 to EXU.
- ex_out_valid  out  1  one-cycle issue pulse to EXU.
- ex_result  in  32  result from EXU.
- ex_exception  in  3  exception from EXU.
- ex_in_valid  in  1  one-cycle completion pulse from EXU.
- timeout_err  out  1  sticky watchdog flag; cleared only by reset.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE, rr_ptr=0. All outputs 0: ex_sig, ex_src1, ex_src2, ex_out_valid, resp_*, timeout_err, busy. req_ready=0 while rst is high.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: round-robin pick among req_valid, searching from rr_ptr upward and wrapping modulo NREQ.
  - Accept = req_valid[i] & req_ready[i] at a clock edge.
  - On accept: latch sig, src1, src2 into ex_*; latch owner id; rr_ptr <= (i+1) mod NREQ; go to ISSUE.
  - No request: stay in IDLE, rr_ptr unchanged.
- Legal sig: exactly one of bits [16:0] set and bits [19:17] all zero.
  - Illegal sig (zero, multi-hot, or any upper bit set) is checked at accept.
  - It goes directly to RESP with resp_exception=3'b111 and resp_result=0.
  - The EXU is never pulsed for it, because the EXU would never answer.
- ISSUE: ex_out_valid=1 for exactly this cycle; ex_sig/ex_src* are stable. Watchdog counter cleared. Next state WAIT.
- WAIT:
  - ex_out_valid=0; ex_sig/ex_src* remain held.
  - ex_in_valid sampled high: capture ex_result/ex_exception; go to RESP.
  - Watchdog reaches TIMEOUT first: resp_result=0, resp_exception=3'b110, timeout_err<=1, go to RESP.
- RESP: resp_valid[owner]=1 for exactly one cycle with result/exception valid; other resp_valid bits 0. Next state IDLE.
  - resp_result/resp_exception hold their values until the next RESP.
  - req_ready stays 0 during RESP. This guarantees at least one idle cycle between the EXU's ex_in_valid and the next ex_out_valid, so the EXU can clear its busy state.
- Issue-to-response latency:
  - Accept edge T; ex_out_valid high in cycle T+1.
  - If ex_in_valid is sampled at edge T+1+L, resp_valid is high in the following cycle.
  - The next accept can occur at the earliest 1 cycle after RESP.
- Spurious ex_in_valid in IDLE, ISSUE or RESP is ignored and does not affect the response.
- ex_in_valid arriving at the same edge the watchdog expires: the real result wins and timeout_err is not set.
- Requester dropping req_valid before a grant: legal, no effect. Held requests must not starve: with all requesters valid, grants rotate 0,1,...,NREQ-1.
- Reset asserted mid-operation: everything is aborted immediately, no resp pulse. The EXU is assumed to be reset by the same rst.

Decomposition:
- Shared package exu_pkg:
  - SIGW.
  - Op bit-index constants: OP_MUL=0 … OP_FSGNJN=16.
  - Exception codes EXC_NONE=3'b000, EXC_TIMEOUT=3'b110, EXC_ILLEGAL=3'b111.
  - State enum.
- One sub-module, rr_arbiter: NREQ-wide combinational round-robin grant from request + pointer. Reusable for the memory port later.

Test Plan:
- Single op: req0 issues mul (sig=20'h00001), src1=7, src2=6; EXU model answers after 5 cycles with 42. Required: exactly one ex_out_valid pulse; resp_valid=01 with resp_result=42, exception 0; req_ready low throughout.
- Contention: req0 and req1 valid together with fadd ops, held continuously for 4 ops. Required: grant order 0,1,0,1; each resp_valid goes to the matching owner; ≥1 cycle gap between ex_in_valid and the next ex_out_valid.
- Illegal op: req1 sig=20'h00003 (multi-hot), then 20'h20000. Required: ex_out_valid never asserted; resp_valid=10 with exception 3'b111 and result 0; the next legal op proceeds normally.
- Timeout: EXU model never responds to a div. Required: resp exception 3'b110 exactly TIMEOUT cycles after issue; timeout_err=1 and stays 1 until rst.
- Race: ex_in_valid at the expiry edge returning 32'hDEADBEEF. Required: result DEADBEEF, exception 0, timeout_err stays 0. Separately, a spurious ex_in_valid in IDLE produces no resp.
- Reset mid-WAIT: assert rst asynchronously between edges during a fdiv. Required: outputs 0 immediately, no resp pulse; after release, rr_ptr=0 and req1-only traffic works.
